// File: rtl/hex_ascii_serializer.sv
// hex_ascii_serializer
// Captures one packed word of NUM_FIELDS fields and streams it out as ASCII
// hex digits, most significant nibble of field 0 first, with an optional
// separator byte between fields. Bytes leave through a valid/ready interface
// towards the UART transmitter.
// Optional feature: define HEX_ASCII_SERIALIZER_CRLF_EN to terminate every
// frame with CR (8'h0D) and LF (8'h0A).
module hex_ascii_serializer #(
    parameter int         NUM_FIELDS = 5,
    parameter int         FIELD_BITS = 8,
    parameter bit         SEP_EN     = 1'b1,
    parameter logic [7:0] SEP_CHAR   = 8'h2C,
    parameter bit         LOWERCASE  = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*FIELD_BITS-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [7:0]                       out_data,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int WORD_W  = NUM_FIELDS * FIELD_BITS;
    localparam int NIBS    = FIELD_BITS / 4;
    localparam int FIELD_W = $clog2(NUM_FIELDS) + 1;
    localparam int NIB_W   = $clog2(NIBS) + 1;

    localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [NIB_W-1:0]   LAST_NIB   = NIB_W'(NIBS - 1);

    // The state always names the byte currently presented on out_data.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_SEP
`ifdef HEX_ASCII_SERIALIZER_CRLF_EN
        ,
        ST_CR,
        ST_LF
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [NIB_W-1:0]     nib_q, nib_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 emit_digit;

    // 4-bit value to its ASCII hex character.
    function automatic logic [7:0] nib_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end
        if (LOWERCASE) begin
            return 8'h57 + {4'h0, v};
        end
        return 8'h37 + {4'h0, v};
    endfunction

    // Nibble n (0 = most significant) of field f within word.
    function automatic logic [3:0] pick_nibble(input logic [WORD_W-1:0]  word,
                                               input logic [FIELD_W-1:0] f,
                                               input logic [NIB_W-1:0]   n);
        int pos;
        pos = int'(f) * FIELD_BITS + (NIBS - 1 - int'(n)) * 4;
        return word[pos +: 4];
    endfunction

    // Next-state and next-output decode; a byte advances only when accepted.
    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        nib_d        = nib_q;
        data_d       = data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        emit_digit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d      = in_data;
                    field_d     = '0;
                    nib_d       = '0;
                    state_d     = ST_DIGIT;
                    out_valid_d = 1'b1;
                    emit_digit  = 1'b1;
                end
            end

            ST_DIGIT: begin
                if (out_ready) begin
                    if (nib_q != LAST_NIB) begin
                        nib_d      = nib_q + 1'b1;
                        emit_digit = 1'b1;
                    end else if (field_q != LAST_FIELD) begin
                        field_d = field_q + 1'b1;
                        nib_d   = '0;
                        if (SEP_EN) begin
                            state_d    = ST_SEP;
                            out_data_d = SEP_CHAR;
                        end else begin
                            emit_digit = 1'b1;
                        end
                    end else begin
`ifdef HEX_ASCII_SERIALIZER_CRLF_EN
                        state_d    = ST_CR;
                        out_data_d = 8'h0D;
`else
                        state_d      = ST_IDLE;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
`endif
                    end
                end
            end

            ST_SEP: begin
                // Counters were already advanced to the next field's first nibble.
                if (out_ready) begin
                    state_d    = ST_DIGIT;
                    emit_digit = 1'b1;
                end
            end

`ifdef HEX_ASCII_SERIALIZER_CRLF_EN
            ST_CR: begin
                if (out_ready) begin
                    state_d    = ST_LF;
                    out_data_d = 8'h0A;
                end
            end

            ST_LF: begin
                if (out_ready) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (emit_digit) begin
            out_data_d = nib_ascii(pick_nibble(data_d, field_d, nib_d));
        end

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, counters, captured word and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            field_q      <= '0;
            nib_q        <= '0;
            data_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            nib_q        <= nib_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Testbench for hex_ascii_serializer: a default-configured instance (A) and a
// 2 x 12-bit, no-separator, lowercase instance (B). Expected frames come from
// a string-level model that formats each field as hex text.
module tb_hex_ascii_serializer;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (5 x 8 bits, comma separator, uppercase)
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [39:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [7:0]  a_out_data;
    logic        a_busy;
    logic        a_frame_done;

    // Instance B: 2 x 12 bits, no separator, lowercase
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [23:0] b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_out_data;
    logic        b_busy;
    logic        b_frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    hex_ascii_serializer u_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .busy       (a_busy),
        .frame_done (a_frame_done)
    );

    hex_ascii_serializer #(
        .NUM_FIELDS (2),
        .FIELD_BITS (12),
        .SEP_EN     (1'b0),
        .SEP_CHAR   (8'h2C),
        .LOWERCASE  (1'b1)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .busy       (b_busy),
        .frame_done (b_frame_done)
    );

    // Reference: each field as hex text (digits from repeated div/mod 16),
    // commas between fields, optional CRLF trailer.
    function automatic bq_t model(input logic [63:0] word, input int nf, input int fb,
                                  input bit sep, input bit lc);
        bq_t        q;
        logic [7:0] digs[$];
        logic [63:0] fld;
        int         d;
        q = {};
        for (int f = 0; f < nf; f++) begin
            fld = (word >> (f * fb)) & ((64'd1 << fb) - 64'd1);
            digs.delete();
            for (int i = 0; i < fb / 4; i++) begin
                d   = int'(fld % 64'd16);
                fld = fld / 64'd16;
                if (d < 10) digs.push_front(8'(48 + d));
                else        digs.push_front(8'((lc ? 97 : 65) + d - 10));
            end
            foreach (digs[i]) q.push_back(digs[i]);
            if (sep && f < nf - 1) q.push_back(8'h2C);
        end
`ifdef HEX_ASCII_SERIALIZER_CRLF_EN
        q.push_back(8'h0D);
        q.push_back(8'h0A);
`endif
        return q;
    endfunction

    // Index of first difference between two byte streams, -1 when identical.
    function automatic int first_diff(input bq_t got, input bq_t exp);
        for (int i = 0; i < exp.size(); i++) begin
            if (i >= got.size()) return i;
            if (got[i] !== exp[i]) return i;
        end
        if (got.size() != exp.size()) return exp.size();
        return -1;
    endfunction

    function automatic logic [7:0] byte_at(input bq_t q, input int i);
        if (i < 0 || i >= q.size()) return 8'hXX;
        return q[i];
    endfunction

    function automatic logic [39:0] rand40();
        return 40'({$urandom(), $urandom()});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [39:0] w);
        a_in_data  = w;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
    endtask

    // Gathers accepted bytes of A until frame_done; optionally pulses
    // in_valid with an all-ones word at cycle 'poke' and leaves it on in_data.
    task automatic collect_a(input int p_ready, input int poke, output bq_t got,
                             output int gaps, output bit ok);
        got  = {};
        gaps = 0;
        ok   = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (a_frame_done) begin
                ok = 1'b1;
                break;
            end
            a_in_valid = (cyc == poke);
            if (cyc == poke) a_in_data = '1;
            a_out_ready = (int'($urandom_range(99)) < p_ready);
            if (!a_out_valid) gaps++;
            if (a_out_valid && a_out_ready) got.push_back(a_out_data);
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
    endtask

    task automatic collect_b(input int p_ready, output bq_t got, output bit ok);
        got = {};
        ok  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (b_frame_done) begin
                ok = 1'b1;
                break;
            end
            b_out_ready = (int'($urandom_range(99)) < p_ready);
            if (b_out_valid && b_out_ready) got.push_back(b_out_data);
            tick();
        end
        b_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 40'h12_3456_789A;
        tick();
        tick();
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_out_data, a_busy, a_frame_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: rdy=%b vld=%b data=%h busy=%b done=%b, required 1 0 00 0 0",
                     a_in_ready, a_out_valid, a_out_data, a_busy, a_frame_done);
        end
        n_cmp++;
        if ({b_in_ready, b_out_valid, b_out_data, b_busy, b_frame_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: rdy=%b vld=%b data=%h busy=%b done=%b, required 1 0 00 0 0",
                     b_in_ready, b_out_valid, b_out_data, b_busy, b_frame_done);
        end
        a_in_valid = 1'b0;
        rst        = 1'b0;
        tick();
        $display("reset: idle outputs checked");
    endtask

    task automatic test_frame_known();
        bq_t got, exp;
        int  gaps, d;
        bit  ok;
        exp = model(64'h12_3456_789A, 5, 8, 1'b1, 1'b0);
        start_a(40'h12_3456_789A);
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_busy, a_out_data} !== {1'b1, 1'b0, 1'b1, 8'h39}) begin
            n_bad++;
            $display("FAIL accept_latency: vld=%b rdy=%b busy=%b data=%h, required 1 0 1 39",
                     a_out_valid, a_in_ready, a_busy, a_out_data);
        end
        collect_a(100, -1, got, gaps, ok);
        d = first_diff(got, exp);
        n_cmp++;
        if (!ok || d != -1) begin
            n_bad++;
            $display("FAIL known_frame: ok=%b len=%0d byte[%0d]=%h, required len=%0d byte=%h",
                     ok, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
        end
        n_cmp++;
        if (gaps != 0) begin
            n_bad++;
            $display("FAIL known_bubbles: %0d idle cycles inside frame, required 0", gaps);
        end
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL frame_end: vld=%b rdy=%b busy=%b, required 0 1 0",
                     a_out_valid, a_in_ready, a_busy);
        end
        tick();
        n_cmp++;
        if (a_frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse_width: frame_done=%b one cycle later, required 0", a_frame_done);
        end
        $display("known frame 40'h123456789A: %0d bytes", got.size());
    endtask

    task automatic test_backpressure();
        bq_t        got, exp;
        int         stall, d;
        bit         prev_stalled, ok;
        logic [7:0] prev_data;
        exp = model(64'h12_3456_789A, 5, 8, 1'b1, 1'b0);
        start_a(40'h12_3456_789A);
        got = {};
        stall = 0;
        prev_stalled = 1'b0;
        prev_data = 8'h00;
        ok = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (a_frame_done) begin
                ok = 1'b1;
                break;
            end
            if (prev_stalled) begin
                n_cmp++;
                if (a_out_valid !== 1'b1 || a_out_data !== prev_data) begin
                    n_bad++;
                    $display("FAIL stall_hold: vld=%b data=%h, required 1 %h",
                             a_out_valid, a_out_data, prev_data);
                end
            end
            if (got.size() == 3 && stall < 3) begin
                a_out_ready = 1'b0;
                stall++;
            end else begin
                a_out_ready = (got.size() > 3) ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (got.size() == 3 && stall == 1) begin
                n_cmp++;
                if (a_out_data !== 8'h37) begin
                    n_bad++;
                    $display("FAIL stall_byte: data=%h, required 37", a_out_data);
                end
            end
            prev_stalled = a_out_valid && !a_out_ready;
            prev_data    = a_out_data;
            if (a_out_valid && a_out_ready) got.push_back(a_out_data);
            tick();
        end
        a_out_ready = 1'b1;
        d = first_diff(got, exp);
        n_cmp++;
        if (!ok || d != -1) begin
            n_bad++;
            $display("FAIL backpressure_frame: ok=%b len=%0d byte[%0d]=%h, required len=%0d byte=%h",
                     ok, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
        end
        tick();
        $display("backpressure frame: %0d bytes, %0d stall cycles at byte 4", got.size(), stall);
    endtask

    task automatic test_random_frames();
        bq_t         got, exp;
        int          gaps, d;
        bit          ok;
        logic [39:0] w;
        for (int k = 0; k < 12; k++) begin
            w   = rand40();
            exp = model(64'(w), 5, 8, 1'b1, 1'b0);
            start_a(w);
            collect_a((k < 4) ? 100 : 60, -1, got, gaps, ok);
            d = first_diff(got, exp);
            n_cmp++;
            if (!ok || d != -1) begin
                n_bad++;
                $display("FAIL random_frame: word=%h ok=%b len=%0d byte[%0d]=%h, required len=%0d byte=%h",
                         w, ok, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
            end
            $display("random frame %0d word=%h: %0d bytes", k, w, got.size());
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        bq_t         got, exp;
        int          gaps, d;
        bit          ok;
        logic [39:0] w;
        w   = rand40();
        exp = model(64'(w), 5, 8, 1'b1, 1'b0);
        start_a(w);
        collect_a(100, 2, got, gaps, ok);
        d = first_diff(got, exp);
        n_cmp++;
        if (!ok || d != -1) begin
            n_bad++;
            $display("FAIL ignore_busy_frame: word=%h ok=%b byte[%0d]=%h, required %h",
                     w, ok, d, byte_at(got, d), byte_at(exp, d));
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_busy_no_queue: vld=%b rdy=%b, required 0 1", a_out_valid, a_in_ready);
        end
        $display("in_valid pulse while busy: frame word=%h intact", w);
    endtask

    task automatic test_reset_midframe();
        bq_t got, exp;
        int  gaps, d, n;
        bit  ok;
        start_a(rand40());
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            if (a_out_valid) n++;
            tick();
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_busy, a_frame_done} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_midframe: vld=%b rdy=%b busy=%b done=%b, required 0 1 0 0",
                     a_out_valid, a_in_ready, a_busy, a_frame_done);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (a_frame_done !== 1'b0 || a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_resume: done=%b vld=%b, required 0 0", a_frame_done, a_out_valid);
        end
        exp = model(64'h0, 5, 8, 1'b1, 1'b0);
        start_a(40'h0);
        collect_a(100, -1, got, gaps, ok);
        d = first_diff(got, exp);
        n_cmp++;
        if (!ok || d != -1) begin
            n_bad++;
            $display("FAIL zero_frame: ok=%b len=%0d byte[%0d]=%h, required len=%0d byte=%h",
                     ok, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
        end
        tick();
        $display("reset at byte 5 then zero frame: %0d bytes", got.size());
    endtask

    task automatic test_back_to_back();
        bq_t         got, exp, part;
        logic [39:0] words[$];
        int          done_cnt, gaps, d;
        bit          started;
        got = {};
        done_cnt = 0;
        gaps = 0;
        started = 1'b0;
        a_out_ready = 1'b1;
        a_in_data   = rand40();
        a_in_valid  = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (a_frame_done) begin
                done_cnt++;
                n_cmp++;
                if (a_in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready_on_done: in_ready=%b, required 1", a_in_ready);
                end
            end
            if (started && !a_out_valid) gaps++;
            if (a_out_valid && a_out_ready) got.push_back(a_out_data);
            if (done_cnt == 3) break;
            if (a_in_ready) begin
                words.push_back(a_in_data);
                started = 1'b1;
            end else begin
                a_in_data = rand40();
            end
            tick();
        end
        a_in_valid = 1'b0;
        exp = {};
        for (int i = 0; i < 3 && i < words.size(); i++) begin
            part = model(64'(words[i]), 5, 8, 1'b1, 1'b0);
            foreach (part[j]) exp.push_back(part[j]);
        end
        d = first_diff(got, exp);
        n_cmp++;
        if (done_cnt != 3 || d != -1) begin
            n_bad++;
            $display("FAIL b2b_stream: frames=%0d len=%0d byte[%0d]=%h, required frames=3 len=%0d byte=%h",
                     done_cnt, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
        end
        n_cmp++;
        if (gaps != 3) begin
            n_bad++;
            $display("FAIL b2b_gaps: %0d idle cycles over 3 frames, required 3", gaps);
        end
        tick();
        $display("back-to-back: %0d frames, %0d bytes, %0d gap cycles", done_cnt, got.size(), gaps);
    endtask

    task automatic test_small_cfg();
        bq_t         got, exp;
        int          d;
        bit          ok;
        logic [23:0] w;
        for (int k = 0; k < 5; k++) begin
            w   = (k == 0) ? 24'hABC_123 : 24'($urandom());
            exp = model(64'(w), 2, 12, 1'b0, 1'b1);
            b_in_data  = w;
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            collect_b((k < 2) ? 100 : 50, got, ok);
            d = first_diff(got, exp);
            n_cmp++;
            if (!ok || d != -1) begin
                n_bad++;
                $display("FAIL small_cfg: word=%h ok=%b len=%0d byte[%0d]=%h, required len=%0d byte=%h",
                         w, ok, got.size(), d, byte_at(got, d), exp.size(), byte_at(exp, d));
            end
            $display("small cfg frame word=%h: %0d bytes", w, got.size());
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_frame_known();
        test_backpressure();
        test_random_frames();
        test_ignore_busy();
        test_reset_midframe();
        test_back_to_back();
        test_small_cfg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
